// File: rtl/h2f_ipc_dispatcher.sv
// Host-to-FPGA IPC command dispatcher: decodes a token to a channel, pulses its
// start line, then follows the channel through accept and run with timeouts.
module h2f_ipc_dispatcher #(
    parameter int TOKEN_WIDTH    = 32,
    parameter int NUM_CH         = 4,
    // entry 0 = "led", 1 = "dac", 2 = "adc", 3 = "fan" (entry i sits at bits i*TOKEN_WIDTH)
    parameter logic [NUM_CH*TOKEN_WIDTH-1:0] TOKEN_LIST =
        {32'h0066616e, 32'h00616463, 32'h00646163, 32'h006c6564},
    parameter int ACCEPT_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [TOKEN_WIDTH-1:0] TOKEN,
    input  logic                   START,
    output logic                   IDLE,
    output logic                   ERROR,
    output logic [1:0]             ERR_CODE,
    output logic [CH_W-1:0]        LAST_CH,
    output logic [NUM_CH-1:0]      CH_START,
    input  logic [NUM_CH-1:0]      CH_IDLE
);

    localparam int ACC_W = $clog2(ACCEPT_CYCLES) + 1;
    localparam int RUN_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PULSE  = 2'd1,
        S_ACCEPT = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [NUM_CH-1:0]   ch_start_r, ch_start_s;
    logic                error_r, error_s;
    logic [1:0]          code_r, code_s;
    logic [CH_W-1:0]     last_ch_r, last_ch_s;
    logic [ACC_W-1:0]    acc_cnt_r, acc_cnt_s, acc_inc_s;
    logic [RUN_W-1:0]    run_cnt_r, run_cnt_s, run_inc_s;
    logic                hit_s;
    logic [CH_W-1:0]     hit_idx_s;
    logic                sel_idle_s;

    // Token lookup; scanning downward lets the lowest matching index win.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (TOKEN == TOKEN_LIST[i*TOKEN_WIDTH +: TOKEN_WIDTH]) begin
                hit_s     = 1'b1;
                hit_idx_s = CH_W'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    assign sel_idle_s = CH_IDLE[last_ch_r];
    assign acc_inc_s  = (acc_cnt_r == {ACC_W{1'b1}}) ? acc_cnt_r : acc_cnt_r + ACC_W'(1);
    assign run_inc_s  = (run_cnt_r == {RUN_W{1'b1}}) ? run_cnt_r : run_cnt_r + RUN_W'(1);

    // Next-state and next-output logic of the dispatch FSM.
    always_comb begin
        state_s    = state_r;
        ch_start_s = '0;
        error_s    = error_r;
        code_s     = code_r;
        last_ch_s  = last_ch_r;
        acc_cnt_s  = acc_cnt_r;
        run_cnt_s  = run_cnt_r;
        case (state_r)
            S_IDLE: begin
                if (START) begin
                    error_s = 1'b0;
                    code_s  = 2'd0;
                    if (!hit_s) begin
                        error_s = 1'b1;
                        code_s  = 2'd1;
                    end else if (!CH_IDLE[hit_idx_s]) begin
                        error_s = 1'b1;
                        code_s  = 2'd2;
                    end else begin
                        last_ch_s = hit_idx_s;
                        state_s   = S_PULSE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PULSE: begin
                ch_start_s = NUM_CH'(1'b1) << last_ch_r;
                acc_cnt_s  = '0;
                state_s    = S_ACCEPT;
            end
            S_ACCEPT: begin
                if (!sel_idle_s) begin
                    run_cnt_s = '0;
                    state_s   = S_RUN;
                end else begin
                    // a channel that never drops idle is taken as already done
                    acc_cnt_s = acc_inc_s;
                    if (acc_inc_s == ACC_W'(ACCEPT_CYCLES)) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_ACCEPT;
                    end
                end
            end
            S_RUN: begin
                if (sel_idle_s) begin
                    state_s = S_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (run_cnt_r == RUN_W'(TIMEOUT_CYCLES))) begin
                    error_s = 1'b1;
                    code_s  = 2'd3;
                    state_s = S_IDLE;
                end else begin
                    run_cnt_s = run_inc_s;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= S_IDLE;
            ch_start_r <= '0;
            error_r    <= 1'b0;
            code_r     <= 2'd0;
            last_ch_r  <= '0;
            acc_cnt_r  <= '0;
            run_cnt_r  <= '0;
        end else begin
            state_r    <= state_s;
            ch_start_r <= ch_start_s;
            error_r    <= error_s;
            code_r     <= code_s;
            last_ch_r  <= last_ch_s;
            acc_cnt_r  <= acc_cnt_s;
            run_cnt_r  <= run_cnt_s;
        end
    end

    assign IDLE     = (state_r == S_IDLE) && !START;
    assign ERROR    = error_r;
    assign ERR_CODE = code_r;
    assign LAST_CH  = last_ch_r;
    assign CH_START = ch_start_r;

endmodule

// File: tb/tb_h2f_ipc_dispatcher.sv
// Scoreboard bench for h2f_ipc_dispatcher: stimulus queues expected pulse and
// completion events with their edge numbers; a monitor pops and compares them.
module tb_h2f_ipc_dispatcher;

    localparam logic [31:0] T_LED = 32'h006c6564;
    localparam logic [31:0] T_DAC = 32'h00646163;
    localparam logic [31:0] T_ADC = 32'h00616463;
    localparam logic [31:0] T_FAN = 32'h0066616e;
    localparam logic [31:0] T_XYZ = 32'h0078797a;
    localparam logic [31:0] T_ABC = 32'h00616263;

    logic        clk = 1'b0;
    logic        resetn, START, START2;
    logic [31:0] TOKEN, TOKEN2;
    logic [3:0]  CH_IDLE, CH_IDLE2;
    logic        IDLE, ERROR, IDLE2, ERROR2;
    logic [1:0]  ERR_CODE, ERR_CODE2, LAST_CH, LAST_CH2;
    logic [3:0]  CH_START, CH_START2;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int e;
    bit prev_idle = 1'b1;

    typedef struct {
        string       name;
        logic [63:0] v;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    h2f_ipc_dispatcher #(.TOKEN_WIDTH(32), .NUM_CH(4), .ACCEPT_CYCLES(16), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .resetn(resetn), .TOKEN(TOKEN), .START(START), .IDLE(IDLE), .ERROR(ERROR),
        .ERR_CODE(ERR_CODE), .LAST_CH(LAST_CH), .CH_START(CH_START), .CH_IDLE(CH_IDLE)
    );

    h2f_ipc_dispatcher #(.TOKEN_WIDTH(32), .NUM_CH(4),
        .TOKEN_LIST({T_LED, T_DAC, T_LED, T_ABC}), .ACCEPT_CYCLES(16), .TIMEOUT_CYCLES(0)) dut2 (
        .clk(clk), .resetn(resetn), .TOKEN(TOKEN2), .START(START2), .IDLE(IDLE2), .ERROR(ERROR2),
        .ERR_CODE(ERR_CODE2), .LAST_CH(LAST_CH2), .CH_START(CH_START2), .CH_IDLE(CH_IDLE2)
    );

    function automatic logic [63:0] pack(input logic kind, input int c, input logic [3:0] chs,
                                         input logic err, input logic [1:0] code, input logic [1:0] last);
        return {22'd0, kind, c[31:0], chs, err, code, last};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%h required=%h (kind,edge,ch_start,err,code,last_ch)", name, act, exp);
    endtask

    task automatic push(input string name, input logic kind, input int c, input logic [3:0] chs,
                        input logic err, input logic [1:0] code, input logic [1:0] last);
        exp_t x;
        x.name = name;
        x.v    = pack(kind, c, chs, err, code, last);
        exp_q.push_back(x);
    endtask

    task automatic observe(input logic kind);
        exp_t x;
        logic [63:0] obs;
        obs = pack(kind, cyc, CH_START, ERROR, ERR_CODE, LAST_CH);
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: actual=%h required=none", obs);
        end else begin
            x = exp_q.pop_front();
            chk(x.name, obs, x.v);
        end
    endtask

    // Monitor: a start pulse or a rising IDLE is an observable DUT event.
    always @(posedge clk) begin
        #1;
        if (CH_START != 4'd0) observe(1'b0);
        if (IDLE && !prev_idle) observe(1'b1);
        prev_idle = IDLE;
    end

    task automatic wait_edge(input int n);
        while (cyc < n - 1) @(negedge clk);
    endtask

    task automatic issue(input logic [31:0] tok);
        START = 1'b1;
        TOKEN = tok;
        @(negedge clk);
        START = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; START = 1'b0; TOKEN = 32'd0; CH_IDLE = 4'hF;
        START2 = 1'b0; TOKEN2 = 32'd0; CH_IDLE2 = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_idle", 64'(IDLE), 64'd1);
        chk("rst_error", 64'(ERROR), 64'd0);
        chk("rst_code", 64'(ERR_CODE), 64'd0);
        chk("rst_last", 64'(LAST_CH), 64'd0);
        chk("rst_ch_start", 64'(CH_START), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // nominal: channel 1 busy from edge e+4, idle again at edge e+24
        e = cyc + 1;
        push("dac_pulse", 1'b0, e + 1, 4'b0010, 1'b0, 2'd0, 2'd1);
        push("dac_done", 1'b1, e + 24, 4'b0000, 1'b0, 2'd0, 2'd1);
        issue(T_DAC);
        wait_edge(e + 4);  CH_IDLE[1] = 1'b0;
        wait_edge(e + 24); CH_IDLE[1] = 1'b1;
        wait_edge(e + 30);

        e = cyc + 1;
        push("unknown_err", 1'b1, e + 1, 4'b0000, 1'b1, 2'd1, 2'd1);
        issue(T_XYZ);
        wait_edge(e + 4);

        // fast channel: pulse at e+1, gives up waiting 16 edges later
        e = cyc + 1;
        push("fan_pulse", 1'b0, e + 1, 4'b1000, 1'b0, 2'd0, 2'd3);
        push("fan_done", 1'b1, e + 17, 4'b0000, 1'b0, 2'd0, 2'd3);
        issue(T_FAN);
        wait_edge(e + 22);

        CH_IDLE[0] = 1'b0;
        e = cyc + 1;
        push("busy_err", 1'b1, e + 1, 4'b0000, 1'b1, 2'd2, 2'd3);
        issue(T_LED);
        wait_edge(e + 3);
        CH_IDLE[0] = 1'b1;
        e = cyc + 1;
        push("led_pulse", 1'b0, e + 1, 4'b0001, 1'b0, 2'd0, 2'd0);
        push("led_done", 1'b1, e + 17, 4'b0000, 1'b0, 2'd0, 2'd0);
        issue(T_LED);
        wait_edge(e + 22);

        // timeout: run entered at edge e+2, fires 101 edges later
        e = cyc + 1;
        push("adc_pulse", 1'b0, e + 1, 4'b0100, 1'b0, 2'd0, 2'd2);
        push("adc_timeout", 1'b1, e + 103, 4'b0000, 1'b1, 2'd3, 2'd2);
        issue(T_ADC);
        wait_edge(e + 2);   CH_IDLE[2] = 1'b0;
        wait_edge(e + 106); CH_IDLE[2] = 1'b1;
        wait_edge(e + 110);

        // reset while running drops the command with reset-valued outputs
        e = cyc + 1;
        push("rerun_pulse", 1'b0, e + 1, 4'b0010, 1'b0, 2'd0, 2'd1);
        push("reset_drop", 1'b1, e + 10, 4'b0000, 1'b0, 2'd0, 2'd0);
        issue(T_DAC);
        wait_edge(e + 2);  CH_IDLE[1] = 1'b0;
        wait_edge(e + 10); resetn = 1'b0;
        @(negedge clk);
        chk("midrst_ch_start", 64'(CH_START), 64'd0);
        chk("midrst_error", 64'(ERROR), 64'd0);
        chk("midrst_last", 64'(LAST_CH), 64'd0);
        chk("midrst_idle", 64'(IDLE), 64'd1);
        resetn = 1'b1; CH_IDLE[1] = 1'b1;
        repeat (3) @(negedge clk);

        // duplicate "led" at 1 and 3 selects 1; no timeout keeps it running
        e = cyc + 1;
        START2 = 1'b1; TOKEN2 = T_LED;
        @(negedge clk);
        START2 = 1'b0;
        @(negedge clk);
        chk("dup_ch_start", 64'(CH_START2), 64'b0010);
        chk("dup_last", 64'(LAST_CH2), 64'd1);
        CH_IDLE2[1] = 1'b0;
        wait_edge(e + 300);
        chk("notimeout_busy", 64'(IDLE2), 64'd0);
        chk("notimeout_error", 64'(ERROR2), 64'd0);
        CH_IDLE2[1] = 1'b1;
        @(negedge clk);
        chk("notimeout_done", 64'(IDLE2), 64'd1);

        repeat (5) @(negedge clk);
        chk("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/h2f_ipc_dispatcher.md
# h2f_ipc_dispatcher

Parametrised host-to-FPGA IPC command dispatcher. Sits between the h2f IPC core (TOKEN/START/IDLE handshake) and up to NUM_CH downstream command modules. It decodes an incoming token against a compile-time token table, pulses the matching channel's start line, and tracks that channel through accept and completion. It adds busy detection, accept/run timeouts and a sticky error report.

## Interface
Parameters:
- TOKEN_WIDTH, 32: width of TOKEN and of each table entry.
- NUM_CH, 4: number of downstream channels, 1..16.
- TOKEN_LIST, {"led","dac","adc","fan"}: NUM_CH packed tokens; entry i = TOKEN_LIST[i*TOKEN_WIDTH +: TOKEN_WIDTH].
- ACCEPT_CYCLES, 16: cycles allowed for a channel to drop its idle after the start pulse, 1..255.
- TIMEOUT_CYCLES, 1_000_000: run-time limit per command; 0 disables it.

Ports (clock and reset: clock clk; reset resetn, synchronous, active-low):
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- TOKEN  in  TOKEN_WIDTH  command token; valid when START=1.
- START  in  1  command request, sampled only while in S_IDLE.
- IDLE  out  1  combinational: (state==S_IDLE) && !START.
- ERROR  out  1  sticky error flag.
- ERR_CODE  out  2  0 none, 1 unknown token, 2 channel busy, 3 run timeout.
- LAST_CH  out  max(1,$clog2(NUM_CH))  index of the last dispatched channel.
- CH_START  out  NUM_CH  one-hot, one-cycle start pulses.
- CH_IDLE  in  NUM_CH  per-channel idle from the downstream modules.

## Operation
- States: S_IDLE, S_PULSE, S_ACCEPT, S_RUN.
- S_IDLE with START=1:
  - ERROR and ERR_CODE clear.
  - TOKEN is compared against all entries. On duplicates, the lowest index wins.
  - No match: ERROR=1, ERR_CODE=1; stay in S_IDLE.
  - Match at idx while CH_IDLE[idx]=0: ERROR=1, ERR_CODE=2; stay in S_IDLE; no pulse.
  - Match at idx while CH_IDLE[idx]=1: latch idx into LAST_CH; go to S_PULSE.
- S_PULSE: register CH_START[idx]=1; clear the accept counter; go to S_ACCEPT.
- S_ACCEPT: CH_START is all zeros.
  - CH_IDLE[idx]=0: go to S_RUN and clear the run counter.
  - Otherwise increment the accept counter. At ACCEPT_CYCLES, the command is treated as completed (fast channel); go to S_IDLE with no error.
- S_RUN:
  - CH_IDLE[idx]=1: go to S_IDLE (completion).
  - Else, if TIMEOUT_CYCLES≠0 and the run counter reaches TIMEOUT_CYCLES: ERROR=1, ERR_CODE=3; go to S_IDLE. The channel is abandoned.
  - Else increment the run counter.
- CH_IDLE bits other than idx are ignored outside S_IDLE. START is ignored outside S_IDLE, where IDLE is already 0.
- Counter widths: $clog2 of the limit plus 1. Counters saturate and never wrap.

## Timing
- Reset values: state=S_IDLE, CH_START=0, ERROR=0, ERR_CODE=0, LAST_CH=0, counters=0. IDLE therefore equals !START during reset.
- Reset mid-operation: CH_START returns to 0 by the next cycle, the state goes to S_IDLE, and any in-flight command is dropped with no error.
- START sampled at edge E0 with a valid token: S_PULSE during E0→E1, then CH_START[idx]=1 for exactly the cycle E1→E2.
- Earliest CH_IDLE sample in S_ACCEPT: edge E2.
- Completion detected at edge En: IDLE=1 from En, provided START=0.
- Error outcomes (codes 1/2) are registered at E0. IDLE stays 0 only during the START cycle, so a back-to-back START on the next cycle is accepted.
- ERROR/ERR_CODE hold until the next accepted START edge or reset.
- Timeout fires on the edge where the run counter equals TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES+1 edges after entering S_RUN.

## Test plan
- Nominal dispatch: TOKEN="dac", START for 1 cycle; channel 1 drops idle 3 cycles after its pulse and raises it 20 cycles later. Required: CH_START=4'b0010 for exactly one cycle at E1; IDLE=1 right after completion; LAST_CH=1; ERROR=0.
- Unknown token: TOKEN="xyz". Required: no CH_START activity; ERROR=1, ERR_CODE=1 from E0; IDLE=1 the next cycle. A following valid START clears ERROR.
- Busy channel: CH_IDLE[0]=0, TOKEN="led". Required: no pulse; ERR_CODE=2. Repeating with CH_IDLE[0]=1 dispatches normally.
- Fast channel: CH_IDLE[3] stays 1 throughout, TOKEN="fan", ACCEPT_CYCLES=16. Required: return to idle 16 cycles after the pulse; ERROR=0.
- Timeout: TIMEOUT_CYCLES=100, channel 2 drops idle and never recovers. Required: ERR_CODE=3 exactly 101 edges after entering S_RUN; IDLE=1 afterwards. With TIMEOUT_CYCLES=0 the block stays in S_RUN indefinitely.
- Reset mid-run plus duplicate tokens: assert resetn=0 while in S_RUN. Required: all outputs at reset values the next cycle. With TOKEN_LIST holding "led" twice, "led" selects only the lower index.
